// File: rtl/mc_inc_n_r.sv
// Split-carry incrementer: the low half of inc_in + 1 is registered along with its carry-out,
// and the high half adds that stored carry combinationally to the live input.
module mc_inc_n_r #(
   parameter int incN_width  = 32,
   parameter int incN_center = incN_width / 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [incN_width-1:0] inc_in,
   output logic [incN_width-1:0] inc_out
);

   localparam int LO_W = incN_center;
   localparam int HI_W = incN_width - incN_center;

   localparam logic [LO_W:0] LO_ONE = (LO_W + 1)'(1);

   logic [LO_W-1:0] lo_r;
   logic            c_r;
   logic [LO_W:0]   lo_sum;
   logic [HI_W-1:0] hi_sum;

   // The sum is one bit wider than the low half so that its top bit is the carry into the high half.
   assign lo_sum = {1'b0, inc_in[LO_W-1:0]} + LO_ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_r <= '0;
         c_r  <= 1'b0;
      end else begin
         // NOTE: use non-blocking assignments so every flop samples pre-edge values, avoiding order-dependent simulation.
         {c_r, lo_r} <= lo_sum;
      end
   end

   // The high half tracks the live input. A change to the high half alone between edges
   // therefore shows up at once, on top of the carry that was stored at the last edge.
   assign hi_sum  = inc_in[incN_width-1:LO_W] + HI_W'(c_r);
   assign inc_out = {hi_sum, lo_r};

endmodule

// File: tb/tb_mc_inc_n_r.sv
// Scoreboard bench for mc_inc_n_r at 24-bit width: stimulus queues expected values,
// and a monitor compares inc_out whenever the sample strobe fires.
module tb_mc_inc_n_r;

   localparam int W = 24;

   typedef struct {
      string        name;
      logic [W-1:0] exp;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] inc_in;
   logic [W-1:0] inc_out;
   logic         sample;

   exp_t sb_q[$];
   int   total;
   int   bad;

   mc_inc_n_r #(.incN_width(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .inc_in  (inc_in),
      .inc_out (inc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops one expectation per strobe and compares it against the DUT output.
   initial begin
      exp_t e;
      forever begin
         @(posedge sample);
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL no_expect: got=%06h want=<none>", inc_out);
         end else begin
            e = sb_q.pop_front();
            if (inc_out !== e.exp) begin
               bad++;
               $display("FAIL %s: got=%06h want=%06h", e.name, inc_out, e.exp);
            end
         end
      end
   end

   task automatic expect_out(input string nm, input logic [W-1:0] exp);
      exp_t e;
      e.name = nm;
      e.exp  = exp;
      sb_q.push_back(e);
      sample = 1'b1;
      #1;
      sample = 1'b0;
   endtask

   // Apply a value at the falling edge, let one rising edge pass, then check.
   task automatic step_edge(input logic [W-1:0] v, input string nm, input logic [W-1:0] exp);
      @(negedge clk);
      inc_in = v;
      @(posedge clk);
      #2;
      expect_out(nm, exp);
   endtask

   // Apply a value between edges and check without any rising edge in between.
   task automatic step_comb(input logic [W-1:0] v, input string nm, input logic [W-1:0] exp);
      @(negedge clk);
      inc_in = v;
      #1;
      expect_out(nm, exp);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      sample = 1'b0;
      rst    = 1'b0;
      inc_in = 24'h123456;

      // Async reset before the first clock edge.
      #1 rst = 1'b1;
      #1 expect_out("reset_async", 24'h123000);
      @(posedge clk);
      #2 expect_out("reset_held", 24'h123000);

      @(negedge clk);
      rst = 1'b0;

      step_edge(24'h000000, "inc_zero",      24'h000001);
      step_edge(24'h00ABC0, "inc_abc0",      24'h00ABC1);
      step_edge(24'h000FFF, "carry_split",   24'h001000);
      step_comb(24'h005FFF, "carry_hi_comb", 24'h006000);
      step_edge(24'hFFFFFF, "wrap",          24'h000000);
      step_edge(24'h7FFFFF, "carry_to_msb",  24'h800000);
      step_edge(24'h800FFE, "no_carry",      24'h800FFF);
      step_edge(24'h000010, "pre_stale",     24'h000011);
      step_comb(24'h000020, "stale_low",     24'h000011);
      step_edge(24'h000020, "stale_fixed",   24'h000021);

      // Reset between edges discards the registered carry and low half at once.
      step_edge(24'h000FFF, "pre_midreset",  24'h001000);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 expect_out("midreset", 24'h000000);
      inc_in = 24'h7A0FFF;
      #1 expect_out("midreset_hi", 24'h7A0000);
      @(negedge clk);
      rst = 1'b0;
      step_edge(24'h000FFF, "post_reset",    24'h001000);

      #2;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got=%0d want=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
